alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq -- sequencer for an external combinational 4-bit ALU.
//
// Accepts one command at a time, drives its operands and opcode onto the ALU
// port, waits SETTLE cycles for the ALU to settle, then captures the result
// into a response register that is held until the downstream accepts it.
// A divide/modulo with a zero divisor never uses the ALU result: it yields
// 8'hFF with rsp_err set, one edge after the command is accepted.
//
// Parameters
//   SETTLE     cycles operands are held on the ALU before capture (1..15)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present          cmd_ready  block can accept (IDLE)
//   cmd_a/b    4-bit operands           cmd_op     3-bit operation select
//   alu_a/b    operands to the ALU      alu_sl     operation select to the ALU
//   alu_out    8-bit ALU result ({quotient,remainder} for op 3)
//   rsp_valid  response present         rsp_ready  downstream accepts
//   rsp_data   captured result          rsp_op     echoed opcode
//   rsp_err    divide-by-zero response  done_cnt   completed responses (wraps)
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sl,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_op,
    output logic       rsp_err,
    output logic [7:0] done_cnt
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);
    localparam logic [2:0] OP_DIVMOD   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;

    logic       cmd_ready_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [2:0] alu_sl_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic [2:0] rsp_op_r;
    logic       rsp_err_r;
    logic [7:0] done_cnt_r;
    logic [3:0] settle_r;
    logic       div_zero_r;

    logic       cmd_ready_nxt_s;
    logic [3:0] alu_a_nxt_s;
    logic [3:0] alu_b_nxt_s;
    logic [2:0] alu_sl_nxt_s;
    logic       rsp_valid_nxt_s;
    logic [7:0] rsp_data_nxt_s;
    logic [2:0] rsp_op_nxt_s;
    logic       rsp_err_nxt_s;
    logic [7:0] done_cnt_nxt_s;
    logic [3:0] settle_nxt_s;
    logic       div_zero_nxt_s;

    logic       accept_s;
    logic       div_zero_s;
    logic       capture_s;
    logic       release_s;

    // Handshake and event decodes shared by the next-state and output logic.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && cmd_valid;
        div_zero_s = (cmd_op == OP_DIVMOD) && (cmd_b == 4'd0);
        // "<= 1" also catches a zero count so DRIVE can never stall.
        capture_s  = (state_r == ST_DRIVE) && (settle_r <= 4'd1);
        release_s  = (state_r == ST_RESP) && rsp_valid_r && rsp_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (capture_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_DRIVE;
                end
            end
            ST_RESP: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and counter.
    always_comb begin
        alu_a_nxt_s     = alu_a_r;
        alu_b_nxt_s     = alu_b_r;
        alu_sl_nxt_s    = alu_sl_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_op_nxt_s    = rsp_op_r;
        rsp_err_nxt_s   = rsp_err_r;
        done_cnt_nxt_s  = done_cnt_r;
        settle_nxt_s    = settle_r;
        div_zero_nxt_s  = div_zero_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    alu_a_nxt_s    = cmd_a;
                    alu_b_nxt_s    = cmd_b;
                    alu_sl_nxt_s   = cmd_op;
                    div_zero_nxt_s = div_zero_s;
                    // Divide-by-zero skips the settle wait: respond next edge.
                    if (div_zero_s) begin
                        settle_nxt_s = 4'd1;
                    end else begin
                        settle_nxt_s = SETTLE_INIT;
                    end
                end else begin
                    settle_nxt_s = settle_r;
                end
            end
            ST_DRIVE: begin
                if (capture_s) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_op_nxt_s    = alu_sl_r;
                    rsp_err_nxt_s   = div_zero_r;
                    settle_nxt_s    = 4'd0;
                    if (div_zero_r) begin
                        rsp_data_nxt_s = 8'hFF;
                    end else begin
                        rsp_data_nxt_s = alu_out;
                    end
                end else begin
                    settle_nxt_s = settle_r - 4'd1;
                end
            end
            ST_RESP: begin
                // Data, opcode and error keep their values after release.
                if (release_s) begin
                    rsp_valid_nxt_s = 1'b0;
                    done_cnt_nxt_s  = done_cnt_r + 8'd1;
                end else begin
                    rsp_valid_nxt_s = rsp_valid_r;
                end
            end
            default: begin
                rsp_valid_nxt_s = 1'b0;
                settle_nxt_s    = 4'd0;
            end
        endcase
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            alu_a_r     <= 4'd0;
            alu_b_r     <= 4'd0;
            alu_sl_r    <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_op_r    <= 3'd0;
            rsp_err_r   <= 1'b0;
            done_cnt_r  <= 8'h00;
            settle_r    <= 4'd0;
            div_zero_r  <= 1'b0;
        end else begin
            cmd_ready_r <= cmd_ready_nxt_s;
            alu_a_r     <= alu_a_nxt_s;
            alu_b_r     <= alu_b_nxt_s;
            alu_sl_r    <= alu_sl_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_op_r    <= rsp_op_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            done_cnt_r  <= done_cnt_nxt_s;
            settle_r    <= settle_nxt_s;
            div_zero_r  <= div_zero_nxt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sl    = alu_sl_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_op    = rsp_op_r;
    assign rsp_err   = rsp_err_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// u1 runs with SETTLE=1 (table vectors, scoreboard, 256-command wrap run);
// u3 runs with SETTLE=3 (back-pressure, held command, reset mid-DRIVE).
// A behavioural ALU model feeds each instance's alu_out from its alu_* port.
// ----------------------------------------------------------------------------
module tb_alu_seq;

    logic clk;
    logic rst_n;

    logic       v1, rdy1, rr1, rv1, re1;
    logic [3:0] a1, b1, aa1, ab1;
    logic [2:0] op1, asl1, rop1;
    logic [7:0] ao1, rd1, dc1;

    logic       v3, rdy3, rr3, rv3, re3;
    logic [3:0] a3, b3, aa3, ab3;
    logic [2:0] op3, asl3, rop3;
    logic [7:0] ao3, rd3, dc3;

    int errors;
    int checks;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] ed;
        logic       ee;
    } vec_t;

    vec_t        vecs [11];
    logic [11:0] sb [$];
    logic [7:0]  exp_done1;

    // Combinational ALU model; 8'hAA on divide-by-zero must never be captured.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0: return {4'd0, a} + {4'd0, b};
            3'd1: return {4'd0, a} - {4'd0, b};
            3'd2: return {4'd0, a} * {4'd0, b};
            3'd3: begin
                if (b == 4'd0) return 8'hAA;
                else return {a / b, a % b};
            end
            3'd4: return {4'd0, a | b};
            3'd5: return {4'd0, a & b};
            3'd6: return {4'd0, a ^ b};
            3'd7: return {4'd0, a} << b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign ao1 = alu_f(aa1, ab1, asl1);
    assign ao3 = alu_f(aa3, ab3, asl3);

    alu_seq #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
        .cmd_a(a1), .cmd_b(b1), .cmd_op(op1),
        .alu_a(aa1), .alu_b(ab1), .alu_sl(asl1), .alu_out(ao1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(rd1), .rsp_op(rop1),
        .rsp_err(re1), .done_cnt(dc1)
    );

    alu_seq #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(rdy3),
        .cmd_a(a3), .cmd_b(b3), .cmd_op(op3),
        .alu_a(aa3), .alu_b(ab3), .alu_sl(asl3), .alu_out(ao3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3), .rsp_op(rop3),
        .rsp_err(re3), .done_cnt(dc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends one command to u1 (rsp_ready held high), pushes the expected
    // response, then pops and compares it when rsp_valid appears.
    task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [7:0] ed, input logic ee);
        int n;
        logic [11:0] e;
        v1 = 1'b1; a1 = a; b1 = b; op1 = op;
        n = 0;
        while (!rdy1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", 32'(n), 32'd0);
            v1 = 1'b0;
            return;
        end
        sb.push_back({ed, op, ee});
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("alu_a", 32'(aa1), 32'(a));
        chk("alu_b", 32'(ab1), 32'(b));
        chk("alu_sl", 32'(asl1), 32'(op));
        chk("busy_ready", 32'(rdy1), 32'd0);
        n = 0;
        while (!rv1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_latency", 32'(n), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_data", 32'(rd1), 32'(e[11:4]));
            chk("rsp_op", 32'(rop1), 32'(e[3:1]));
            chk("rsp_err", 32'(re1), 32'(e[0]));
        end
        exp_done1 = exp_done1 + 8'd1;
    endtask

    // Waits for u1 to return to IDLE, then checks the completion count.
    task automatic drain1();
        int n;
        n = 0;
        while (!rdy1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", 32'(n < 40), 32'd1);
        chk("done_cnt1", 32'(dc1), 32'(exp_done1));
    endtask

    initial begin
        int n;
        errors = 0; checks = 0; exp_done1 = 8'h00;
        rst_n = 1'b0;
        v1 = 1'b0; a1 = 4'd0; b1 = 4'd0; op1 = 3'd0; rr1 = 1'b1;
        v3 = 1'b0; a3 = 4'd0; b3 = 4'd0; op3 = 3'd0; rr3 = 1'b0;

        vecs[0]  = '{4'd13, 4'd4,  3'd3, 8'h31, 1'b0};
        vecs[1]  = '{4'd9,  4'd0,  3'd3, 8'hFF, 1'b1};
        vecs[2]  = '{4'd5,  4'd7,  3'd1, 8'hFE, 1'b0};
        vecs[3]  = '{4'd15, 4'd15, 3'd2, 8'hE1, 1'b0};
        vecs[4]  = '{4'd10, 4'd12, 3'd4, 8'h0E, 1'b0};
        vecs[5]  = '{4'd10, 4'd12, 3'd5, 8'h08, 1'b0};
        vecs[6]  = '{4'd10, 4'd12, 3'd6, 8'h06, 1'b0};
        vecs[7]  = '{4'd3,  4'd2,  3'd7, 8'h0C, 1'b0};
        vecs[8]  = '{4'd0,  4'd0,  3'd3, 8'hFF, 1'b1};
        vecs[9]  = '{4'd15, 4'd1,  3'd3, 8'hF0, 1'b0};
        vecs[10] = '{4'd7,  4'd15, 3'd0, 8'h16, 1'b0};

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rv1), 32'd0);
        chk("rst_rsp_data", 32'(rd1), 32'h00);
        chk("rst_rsp_err", 32'(re1), 32'd0);
        chk("rst_rsp_op", 32'(rop1), 32'd0);
        chk("rst_alu_a", 32'(aa1), 32'd0);
        chk("rst_alu_sl", 32'(asl1), 32'd0);
        chk("rst_done_cnt", 32'(dc1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready1", 32'(rdy1), 32'd1);
        chk("rst_cmd_ready3", 32'(rdy3), 32'd1);

        // Basic add, SETTLE=1: one-edge latency, done_cnt reaches 1.
        send1(4'd4, 4'd3, 3'd0, 8'h07, 1'b0);
        drain1();

        // Table vectors covering every opcode and both divide cases.
        for (int i = 0; i < 11; i++) begin
            send1(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ed, vecs[i].ee);
        end
        drain1();

        // SETTLE=3 with back-pressure and a second command held during DRIVE.
        v3 = 1'b1; a3 = 4'd15; b3 = 4'd15; op3 = 3'd2;
        @(posedge clk); #1;
        chk("u3_accept_ready", 32'(rdy3), 32'd0);
        chk("u3_alu_a", 32'(aa3), 32'd15);
        chk("u3_alu_sl", 32'(asl3), 32'd2);
        a3 = 4'd2; b3 = 4'd3; op3 = 3'd0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            chk("u3_settle_wait", 32'(rv3), 32'd0);
        end
        @(posedge clk); #1;
        chk("u3_rsp_valid", 32'(rv3), 32'd1);
        chk("u3_rsp_data", 32'(rd3), 32'hE1);
        chk("u3_rsp_op", 32'(rop3), 32'd2);
        chk("u3_rsp_err", 32'(re3), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("u3_hold_valid", 32'(rv3), 32'd1);
            chk("u3_hold_data", 32'(rd3), 32'hE1);
            chk("u3_hold_op", 32'(rop3), 32'd2);
            chk("u3_hold_ready", 32'(rdy3), 32'd0);
            chk("u3_hold_alu_a", 32'(aa3), 32'd15);
        end
        rr3 = 1'b1;
        @(posedge clk); #1;
        chk("u3_release_valid", 32'(rv3), 32'd0);
        chk("u3_release_ready", 32'(rdy3), 32'd1);
        chk("u3_done_1", 32'(dc3), 32'd1);
        chk("u3_keep_data", 32'(rd3), 32'hE1);
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("u3_second_alu_a", 32'(aa3), 32'd2);
        chk("u3_second_alu_sl", 32'(asl3), 32'd0);
        n = 0;
        while (!rv3 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("u3_latency", 32'(n), 32'd3);
        chk("u3_second_data", 32'(rd3), 32'h05);
        chk("u3_second_op", 32'(rop3), 32'd0);
        @(posedge clk); #1;
        chk("u3_done_2", 32'(dc3), 32'd2);

        // Reset pulsed mid-DRIVE aborts the command asynchronously.
        v3 = 1'b1; a3 = 4'd5; b3 = 4'd6; op3 = 3'd0;
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("u3_pre_rst_alu_a", 32'(aa3), 32'd5);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rv3), 32'd0);
        chk("arst_rsp_data", 32'(rd3), 32'h00);
        chk("arst_alu_a", 32'(aa3), 32'd0);
        chk("arst_alu_b", 32'(ab3), 32'd0);
        chk("arst_done_cnt", 32'(dc3), 32'd0);
        chk("arst_done_cnt1", 32'(dc1), 32'd0);
        exp_done1 = 8'h00;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", 32'(rv3), 32'd0);
        end
        chk("post_rst_done", 32'(dc3), 32'd0);
        chk("post_rst_ready", 32'(rdy3), 32'd1);
        chk("post_rst_no_accept", 32'(aa3), 32'd0);

        // 256 back-to-back adds: done_cnt wraps to zero.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            send1(iv[3:0], iv[7:4], 3'd0, {4'd0, iv[3:0]} + {4'd0, iv[7:4]}, 1'b0);
        end
        drain1();
        chk("wrap_done_cnt", 32'(dc1), 32'h00);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
